// File: rtl/fft_pingpong_mem.sv
// fft_pingpong_mem: ping-pong sample memory for the radix-2 FFT datapath.
// Two banks of N words {Re,Im}. One transform runs LOAD -> COMPUTE -> UNLOAD.
// Banks swap roles after every stage, and the final result is unloaded in natural index order.
// Optional macro FFT_MEM_BITREV_EN: LOAD writes sample k at bit-reverse(k) instead of k.
//
// Handshakes (in_valid/in_ready, out_valid/out_ready): a word transfers on a
// posedge where valid && ready. Once the producer raises valid, it holds valid
// and data stable until that transfer. ready may change freely.
module fft_pingpong_mem #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 512,
    parameter int M         = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*BIT_WIDTH-1:0] in_data,
    input  logic [M-1:0]           rd_adr_a,
    input  logic [M-1:0]           rd_adr_b,
    output logic [2*BIT_WIDTH-1:0] rd_a,
    output logic [2*BIT_WIDTH-1:0] rd_b,
    input  logic                   we,
    input  logic [M-1:0]           wr_adr_a,
    input  logic [M-1:0]           wr_adr_b,
    input  logic [2*BIT_WIDTH-1:0] wd_a,
    input  logic [2*BIT_WIDTH-1:0] wd_b,
    input  logic                   stage_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*BIT_WIDTH-1:0] out_data,
    output logic                   bank_sel,
    output logic [M-1:0]           stage,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state_dbg
);

    localparam int W = 2 * BIT_WIDTH;
    localparam logic [M:0]   CNT_LAST   = (M+1)'(N - 1);
    localparam logic [M:0]   CNT_END    = (M+1)'(N);
    localparam logic [M:0]   CNT_ONE    = (M+1)'(1);
    localparam logic [M-1:0] STAGE_LAST = M'(M - 1);
    localparam logic [M-1:0] STAGE_ONE  = M'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_UNLOAD  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [W-1:0] bank0 [N];
    logic [W-1:0] bank1 [N];

    // load_cnt: samples accepted so far. unl_idx: next result index to fetch.
    logic [M:0]   load_cnt;
    logic [M:0]   unl_idx;
    logic [M-1:0] load_adr;

    logic load_fire, load_last;
    logic stage_fire, stage_last;
    logic out_fire, unl_last;
    logic fetch, wr_en_c;

    function automatic logic [M-1:0] bit_rev(input logic [M-1:0] a);
        logic [M-1:0] r;
        for (int i = 0; i < M; i++) begin
            r[i] = a[M-1-i];
        end
        return r;
    endfunction

`ifdef FFT_MEM_BITREV_EN
    assign load_adr = bit_rev(load_cnt[M-1:0]);
`else
    assign load_adr = load_cnt[M-1:0];
`endif

    assign load_fire  = in_valid && in_ready;
    assign load_last  = load_fire && (load_cnt == CNT_LAST);
    assign stage_fire = (state == S_COMPUTE) && stage_done;
    assign stage_last = stage_fire && (stage == STAGE_LAST);
    assign out_fire   = out_valid && out_ready;
    // unl_idx == N means word N-1 is the one currently presented
    assign unl_last   = out_fire && (unl_idx == CNT_END);
    // Refill the output register when it is empty or being drained this cycle
    assign fetch      = (state == S_UNLOAD) && (unl_idx != CNT_END) && (!out_valid || out_ready);
    // Writes are gated by reset so that an abort leaves the RAM untouched
    assign wr_en_c    = (state == S_COMPUTE) && we && !reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start)      state_nx = S_LOAD;
            S_LOAD:    if (load_last)  state_nx = S_COMPUTE;
            S_COMPUTE: if (stage_last) state_nx = S_UNLOAD;
            S_UNLOAD:  if (unl_last)   state_nx = S_IDLE;
            default:                   state_nx = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = (state == S_LOAD);
        busy      = (state != S_IDLE);
        state_dbg = state;
    end

    // Bank 0: LOAD target, and write bank while bank 1 is being read. The second assignment wins on an address clash.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_fire) bank0[load_adr] <= in_data;
            if (wr_en_c && bank_sel) begin
                bank0[wr_adr_a] <= wd_a;
                bank0[wr_adr_b] <= wd_b;
            end
        end
    end

    // Bank 1: write bank while bank 0 is being read. The second assignment wins on an address clash.
    always_ff @(posedge clk) begin
        if (wr_en_c && !bank_sel) begin
            bank1[wr_adr_a] <= wd_a;
            bank1[wr_adr_b] <= wd_b;
        end
    end

    // Engine read ports: registered reads of the read bank, holding outside COMPUTE
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_a <= '0;
            rd_b <= '0;
        end else if (state == S_COMPUTE) begin
            rd_a <= bank_sel ? bank1[rd_adr_a] : bank0[rd_adr_a];
            rd_b <= bank_sel ? bank1[rd_adr_b] : bank0[rd_adr_b];
        end
    end

    // Phase counters, bank select and stage count
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt <= '0;
            unl_idx  <= '0;
            bank_sel <= 1'b0;
            stage    <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                load_cnt <= '0;
                bank_sel <= 1'b0;
                stage    <= '0;
            end
            if (load_fire) begin
                load_cnt <= load_cnt + CNT_ONE;
                if (load_last) begin
                    bank_sel <= 1'b0;
                    stage    <= '0;
                end
            end
            if (stage_fire) begin
                bank_sel <= ~bank_sel;
                stage    <= stage_last ? '0 : stage + STAGE_ONE;
                if (stage_last) unl_idx <= '0;
            end
            if (fetch) unl_idx <= unl_idx + CNT_ONE;
        end
    end

    // Result stream: the output register reads the result bank (bank_sel) and holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= unl_last;
            if (fetch) begin
                out_valid <= 1'b1;
                out_data  <= bank_sel ? bank1[unl_idx[M-1:0]] : bank0[unl_idx[M-1:0]];
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_pingpong_mem.sv
// tb_fft_pingpong_mem: directed bench for fft_pingpong_mem with N=8, M=3, BIT_WIDTH=16.
module tb_fft_pingpong_mem;

    localparam int BW = 16;
    localparam int N  = 8;
    localparam int M  = 3;
    localparam int W  = 2 * BW;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_UNLOAD  = 2'd3;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [M-1:0] rd_adr_a = '0;
    logic [M-1:0] rd_adr_b = '0;
    logic [W-1:0] rd_a, rd_b;
    logic         we = 1'b0;
    logic [M-1:0] wr_adr_a = '0;
    logic [M-1:0] wr_adr_b = '0;
    logic [W-1:0] wd_a = '0;
    logic [W-1:0] wd_b = '0;
    logic         stage_done = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         bank_sel;
    logic [M-1:0] stage;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    fft_pingpong_mem #(.BIT_WIDTH(BW), .N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b), .rd_a(rd_a), .rd_b(rd_b),
        .we(we), .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b), .wd_a(wd_a), .wd_b(wd_b),
        .stage_done(stage_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bank_sel(bank_sel), .stage(stage), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // scoreboard
    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1ns after the edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [M-1:0] rev3(input logic [M-1:0] a);
        return {a[0], a[1], a[2]};
    endfunction

    // word stored at address a after loading samples k = 0..7
    function automatic logic [W-1:0] loaded_word(input logic [M-1:0] a);
`ifdef FFT_MEM_BITREV_EN
        return W'(rev3(a));
`else
        return W'(a);
`endif
    endfunction

    initial begin : stim
        int accepted;
        int cyc;
        logic prev_stall;
        logic [W-1:0] prev_data;
        logic [M-1:0] a;

        // reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", W'(state_dbg), W'(ST_IDLE));
        check("rst_busy", W'(busy), '0);
        check("rst_in_ready", W'(in_ready), '0);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_done", W'(done), '0);
        check("rst_bank_sel", W'(bank_sel), '0);
        check("rst_stage", W'(stage), '0);
        check("rst_rd_a", rd_a, '0);
        check("rst_rd_b", rd_b, '0);
        check("rst_out_data", out_data, '0);

        // abort a load with reset after 3 samples
        pulse_start();
        check("load_state", W'(state_dbg), W'(ST_LOAD));
        check("load_in_ready", W'(in_ready), W'(1));
        check("load_busy", W'(busy), W'(1));
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'hDEAD_0000 + W'(k);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state", W'(state_dbg), W'(ST_IDLE));
        check("abort_busy", W'(busy), '0);
        check("abort_in_ready", W'(in_ready), '0);

        // fresh transform: load samples k = 0..7
        pulse_start();
        in_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_data = W'(k);
            tick();
        end
        in_valid = 1'b0;
        check("cmp_state", W'(state_dbg), W'(ST_COMPUTE));
        check("cmp_in_ready", W'(in_ready), '0);
        check("cmp_bank_sel", W'(bank_sel), '0);
        check("cmp_stage", W'(stage), '0);

        // read back every loaded word through both ports
        for (int i = 0; i < N; i++) begin
            a = M'(i);
            rd_adr_a = a;
            rd_adr_b = ~a;
            tick();
            check($sformatf("load_rd_a[%0d]", i), rd_a, loaded_word(a));
            check($sformatf("load_rd_b[%0d]", 7 - i), rd_b, loaded_word(~a));
        end

        // stage 0: colliding write into bank 1 together with stage_done
        we = 1'b1;
        wr_adr_a = 3'd2;
        wr_adr_b = 3'd2;
        wd_a = 32'hAAAA_AAAA;
        wd_b = 32'hBBBB_BBBB;
        stage_done = 1'b1;
        tick();
        we = 1'b0;
        stage_done = 1'b0;
        check("s0_bank_sel", W'(bank_sel), W'(1));
        check("s0_stage", W'(stage), W'(1));
        rd_adr_a = 3'd2;
        tick();
        check("s0_collide", rd_a, 32'hBBBB_BBBB);

        // stage 1: write 0x100+k into bank 0
        for (int j = 0; j < 4; j++) begin
            we = 1'b1;
            wr_adr_a = M'(2 * j);
            wr_adr_b = M'(2 * j + 1);
            wd_a = 32'h100 + W'(2 * j);
            wd_b = 32'h100 + W'(2 * j + 1);
            stage_done = (j == 3);
            tick();
        end
        we = 1'b0;
        stage_done = 1'b0;
        check("s1_bank_sel", W'(bank_sel), '0);
        check("s1_stage", W'(stage), W'(2));
        rd_adr_a = 3'd5;
        rd_adr_b = 3'd2;
        tick();
        check("s1_rd_a5", rd_a, 32'h105);
        check("s1_rd_b2", rd_b, 32'h102);

        // start during COMPUTE is ignored
        pulse_start();
        check("ign_start_state", W'(state_dbg), W'(ST_COMPUTE));
        check("ign_start_stage", W'(stage), W'(2));
        check("ign_start_bank", W'(bank_sel), '0);

        // stage 2: write 0x100+k into bank 1; last stage_done moves to UNLOAD
        for (int j = 0; j < 4; j++) begin
            we = 1'b1;
            wr_adr_a = M'(2 * j);
            wr_adr_b = M'(2 * j + 1);
            wd_a = 32'h100 + W'(2 * j);
            wd_b = 32'h100 + W'(2 * j + 1);
            stage_done = (j == 3);
            tick();
        end
        we = 1'b0;
        stage_done = 1'b0;
        check("unl_state", W'(state_dbg), W'(ST_UNLOAD));
        check("unl_bank_sel", W'(bank_sel), W'(1));
        check("unl_stage", W'(stage), '0);

        // unload with out_ready toggling 1/0
        for (int k = 0; k < N; k++) exp_q.push_back(32'h100 + W'(k));
        accepted = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        while (accepted < N && cyc < 100) begin
            out_ready = ((cyc % 2) == 0);
            if (prev_stall) begin
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                check($sformatf("out_data[%0d]", accepted), out_data, exp_q.pop_front());
                accepted++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("unl_count", W'(accepted), W'(N));
        check("done_pulse", W'(done), W'(1));
        check("done_busy", W'(busy), '0);
        check("done_state", W'(state_dbg), W'(ST_IDLE));
        check("done_out_valid", W'(out_valid), '0);
        tick();
        check("done_clear", W'(done), '0);

        // stage_done and we in IDLE are ignored; rd_a holds its last COMPUTE value
        rd_adr_a = 3'd3;
        stage_done = 1'b1;
        we = 1'b1;
        tick();
        stage_done = 1'b0;
        we = 1'b0;
        check("idle_state", W'(state_dbg), W'(ST_IDLE));
        check("idle_stage", W'(stage), '0);
        check("idle_bank_sel", W'(bank_sel), W'(1));
        check("idle_rd_a_hold", rd_a, 32'h105);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
